// File: rtl/spe_timestep_sched_if.sv
// Handshake bundle between the timestep scheduler and its requesters / SPE.
// master = scheduler side, slave = requesters + SPE side.
interface spe_timestep_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 25,
  parameter int PKT_W   = 33
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic                           spe_valid;
  logic                           spe_ready;
  logic [PKT_W-1:0]               spe_packet;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [PKT_W-1:0]               rsp_packet;

  modport master (
    input  req_valid, req_data, spe_ready, rsp_valid, rsp_packet,
    output req_ready, spe_valid, spe_packet, rsp_ready
  );

  modport slave (
    output req_valid, req_data, spe_ready, rsp_valid, rsp_packet,
    input  req_ready, spe_valid, spe_packet, rsp_ready
  );
endinterface

// File: rtl/spe_timestep_sched.sv
// Round-robin partial-sum scheduler for one SPE: streams psums, then the timestep-done
// and previous-potential packets, then latches the SPE's new potential.
module spe_timestep_sched #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int OP_W    = 4,
  parameter int DATA_W  = 25,
  parameter int CNT_W   = 8,
  parameter int TS_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [CNT_W-1:0]     cfg_psum_cnt,
  input  logic [DATA_W-1:0]    cfg_init_pot,
  input  logic                 start,
  spe_timestep_sched_if.master bus,
  output logic                 ts_done,
  output logic [TS_W-1:0]      ts_count,
  output logic                 busy
);
  localparam int PKT_W = ADDR_W + OP_W + DATA_W;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PSUM   = 3'd1;
  localparam logic [2:0] S_TSFLAG = 3'd2;
  localparam logic [2:0] S_POT    = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  localparam logic [OP_W-1:0] OP_PSUM   = '0;
  localparam logic [OP_W-1:0] OP_TSFLAG = OP_W'(15);
  localparam logic [OP_W-1:0] OP_POT    = OP_W'(2);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  seen_q, seen_d;
  logic [DATA_W-1:0] pot_q, pot_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              out_vld_q, out_vld_d;
  logic [PKT_W-1:0]  out_pkt_q, out_pkt_d;
  logic              ts_done_q, ts_done_d;
  logic [TS_W-1:0]   ts_cnt_q, ts_cnt_d;

  logic               load_ok;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gidx;
  logic               gfound;
  logic [DATA_W-1:0]  gdata;
  logic               accept;
  logic               rsp_fire;
  logic               unused_rsp_hdr;

  // Output register is a one-entry skid: loadable when empty or draining this cycle.
  assign load_ok = !out_vld_q || bus.spe_ready;

  always_comb begin
    int idx;
    grant  = '0;
    gidx   = '0;
    gfound = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!gfound && bus.req_valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = PTR_W'(idx);
        gfound     = 1'b1;
      end
    end
  end

  assign gdata         = bus.req_data[gidx];
  assign bus.req_ready = (state_q == S_PSUM && load_ok) ? grant : '0;
  assign accept        = (state_q == S_PSUM) && load_ok && gfound;
  // The response is only taken once the POT packet has left, so ordering holds on exit.
  assign bus.rsp_ready = (state_q == S_WAIT) && !out_vld_q;
  assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;
  assign unused_rsp_hdr = ^bus.rsp_packet[PKT_W-1:DATA_W];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    seen_d    = seen_q;
    pot_d     = pot_q;
    ptr_d     = ptr_q;
    ts_cnt_d  = ts_cnt_q;
    ts_done_d = 1'b0;
    out_vld_d = out_vld_q && !bus.spe_ready;
    out_pkt_d = out_pkt_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          addr_d = cfg_addr;
          cnt_d  = cfg_psum_cnt;
          pot_d  = cfg_init_pot;
        end
        if (start) begin
          seen_d  = '0;
          state_d = (cnt_d == '0) ? S_TSFLAG : S_PSUM;
        end
      end
      S_PSUM: begin
        if (accept) begin
          out_vld_d = 1'b1;
          out_pkt_d = {addr_q, OP_PSUM, gdata};
          seen_d    = seen_q + 1'b1;
          ptr_d     = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          if (seen_d == cnt_q) state_d = S_TSFLAG;
        end
      end
      S_TSFLAG: begin
        if (load_ok) begin
          out_vld_d = 1'b1;
          out_pkt_d = {addr_q, OP_TSFLAG, {DATA_W{1'b0}}};
          state_d   = S_POT;
        end
      end
      S_POT: begin
        if (load_ok) begin
          out_vld_d = 1'b1;
          out_pkt_d = {addr_q, OP_POT, pot_q};
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_fire) begin
          pot_d     = bus.rsp_packet[DATA_W-1:0];
          ts_done_d = 1'b1;
          ts_cnt_d  = ts_cnt_q + 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      seen_q    <= '0;
      pot_q     <= '0;
      ptr_q     <= '0;
      out_vld_q <= 1'b0;
      out_pkt_q <= '0;
      ts_done_q <= 1'b0;
      ts_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
      pot_q     <= pot_d;
      ptr_q     <= ptr_d;
      out_vld_q <= out_vld_d;
      out_pkt_q <= out_pkt_d;
      ts_done_q <= ts_done_d;
      ts_cnt_q  <= ts_cnt_d;
    end
  end

  assign bus.spe_valid  = out_vld_q;
  assign bus.spe_packet = out_pkt_q;
  assign ts_done        = ts_done_q;
  assign ts_count       = ts_cnt_q;
  assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_spe_timestep_sched.sv
// Directed bench for spe_timestep_sched: a packet-stream model checked every cycle,
// plus literal expectations per scenario.
module tb_spe_timestep_sched;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 25;
  localparam int PKT_W   = 33;
  localparam int TS_W    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, cfg_we, start;
  logic [3:0]        cfg_addr;
  logic [7:0]        cfg_psum_cnt;
  logic [24:0]       cfg_init_pot;
  logic              ts_done, busy;
  logic [TS_W-1:0]   ts_count;

  spe_timestep_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PKT_W(PKT_W)) bus ();

  spe_timestep_sched #(.NUM_REQ(NUM_REQ), .ADDR_W(4), .OP_W(4), .DATA_W(DATA_W),
                       .CNT_W(8), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_psum_cnt(cfg_psum_cnt), .cfg_init_pot(cfg_init_pot), .start(start),
    .bus(bus), .ts_done(ts_done), .ts_count(ts_count), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int rq [NUM_REQ][$];
  logic [PKT_W-1:0] plog[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [PKT_W-1:0] pk(input logic [3:0] a, input logic [3:0] op,
                                          input logic [24:0] d);
    return {a, op, d};
  endfunction

  // Model: phase 0 idle, 1 collecting psums, 2 draining tail / awaiting response.
  int               m_phase, m_cnt, m_seen, m_ptr, m_ts, g, mi;
  logic [3:0]       m_addr, eg;
  logic [24:0]      m_pot;
  bit               m_slot_v, m_done, m_free, m_drained, m_rsp_rdy;
  logic [PKT_W-1:0] m_slot;
  logic [PKT_W-1:0] m_stream[$];

  initial begin : cmp
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs", {bus.spe_valid, bus.spe_packet, bus.req_ready, bus.rsp_ready,
                              ts_done, ts_count, busy}, '0);
        m_phase = 0; m_cnt = 0; m_seen = 0; m_ptr = 0; m_ts = 0; m_addr = '0; m_pot = '0;
        m_slot_v = 0; m_slot = '0; m_done = 0; m_stream.delete();
      end else begin
        m_free    = !m_slot_v || bus.spe_ready;
        m_drained = m_slot_v && bus.spe_ready;
        g = -1;
        eg = '0;
        if (m_phase == 1 && m_free)
          for (int k = 0; k < NUM_REQ; k++) begin
            mi = (m_ptr + k) % NUM_REQ;
            if (g < 0 && bus.req_valid[mi]) g = mi;
          end
        if (g >= 0) eg[g] = 1'b1;
        m_rsp_rdy = (m_phase == 2) && (m_stream.size() == 0) && !m_slot_v;

        chk("spe_valid", bus.spe_valid, m_slot_v);
        if (m_slot_v) chk("spe_packet", bus.spe_packet, m_slot);
        chk("req_ready", bus.req_ready, eg);
        chk("rsp_ready", bus.rsp_ready, m_rsp_rdy);
        chk("ts_done", ts_done, m_done);
        chk("ts_count", ts_count, m_ts);
        chk("busy", busy, m_phase != 0);
        if (bus.spe_valid && bus.spe_ready) plog.push_back(bus.spe_packet);

        if (g >= 0) begin
          m_slot_v = 1; m_slot = pk(m_addr, 4'd0, bus.req_data[g]);
        end else if (m_free && m_stream.size() > 0) begin
          m_slot_v = 1; m_slot = m_stream.pop_front();
        end else if (m_drained) m_slot_v = 0;
        m_done = 0;
        case (m_phase)
          0: begin
            if (cfg_we) begin
              m_addr = cfg_addr; m_cnt = int'(cfg_psum_cnt); m_pot = cfg_init_pot;
            end
            if (start) begin
              m_seen = 0;
              if (m_cnt == 0) begin
                m_phase = 2;
                m_stream.push_back(pk(m_addr, 4'd15, 25'd0));
                m_stream.push_back(pk(m_addr, 4'd2, m_pot));
              end else m_phase = 1;
            end
          end
          1: if (g >= 0) begin
            m_seen++;
            m_ptr = (g + 1) % NUM_REQ;
            if (m_seen == m_cnt) begin
              m_phase = 2;
              m_stream.push_back(pk(m_addr, 4'd15, 25'd0));
              m_stream.push_back(pk(m_addr, 4'd2, m_pot));
            end
          end
          default: if (m_rsp_rdy && bus.rsp_valid) begin
            m_pot = bus.rsp_packet[24:0];
            m_ts = (m_ts + 1) % (1 << TS_W);
            m_done = 1;
            m_phase = 0;
          end
        endcase
      end
    end
  end

  // Requester driver: each requester presents the head of its queue until accepted.
  initial begin : drv
    logic [NUM_REQ-1:0] f;
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      f = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (f[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        bus.req_valid[i] = (rq[i].size() > 0);
        bus.req_data[i]  = (rq[i].size() > 0) ? 25'(rq[i][0]) : 25'd0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] a, input logic [7:0] c, input logic [24:0] p);
    cfg_we = 1; cfg_addr = a; cfg_psum_cnt = c; cfg_init_pot = p;
    tick();
    cfg_we = 0;
  endtask

  task automatic start_ts();
    start = 1;
    tick();
    start = 0;
  endtask

  // rsp_valid is raised early on purpose: it must not be taken before WAIT_RSP.
  task automatic run_rsp(input logic [24:0] d);
    int n;
    n = 0;
    bus.rsp_packet = {8'h00, d};
    bus.rsp_valid  = 1;
    while (!bus.rsp_ready && n < 200) begin
      tick();
      n++;
    end
    chk("rsp_handshake_reached", bus.rsp_ready, 1);
    tick();
    bus.rsp_valid = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    rst_n = 0; cfg_we = 0; start = 0; cfg_addr = '0; cfg_psum_cnt = '0; cfg_init_pot = '0;
    bus.spe_ready = 0; bus.rsp_valid = 0; bus.rsp_packet = '0;
    tick(); tick();
    chk("rst_spe_valid", bus.spe_valid, 0);
    chk("rst_spe_packet", bus.spe_packet, 0);
    chk("rst_ts_count", ts_count, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    rst_n = 1;
    tick();

    // Test 1: single requester, five psums, then flag and potential packets.
    cfg(4'd3, 8'd5, 25'd60);
    bus.spe_ready = 1;
    for (int i = 0; i < 5; i++) rq[0].push_back(i);
    plog.delete();
    start_ts();
    run_rsp(25'd75);
    chk("t1_ts_done", ts_done, 1);
    chk("t1_ts_count", ts_count, 1);
    chk("t1_busy", busy, 0);
    chk("t1_len", plog.size(), 7);
    if (plog.size() == 7) begin
      for (int i = 0; i < 5; i++) chk("t1_psum", plog[i], pk(4'd3, 4'd0, 25'(i)));
      chk("t1_flag", plog[5], pk(4'd3, 4'd15, 25'd0));
      chk("t1_pot", plog[6], pk(4'd3, 4'd2, 25'd60));
    end
    for (int i = 5; i < 10; i++) rq[0].push_back(i);
    plog.delete();
    start_ts();
    run_rsp(25'd80);
    chk("t1b_len", plog.size(), 7);
    if (plog.size() == 7) chk("t1b_pot_carried", plog[6], pk(4'd3, 4'd2, 25'd75));
    chk("t1b_ts_count", ts_count, 2);

    // Test 2: all four requesters, round-robin order and pointer wrap.
    rst_n = 0; tick(); rst_n = 1; tick();
    cfg(4'd5, 8'd4, 25'd7);
    for (int i = 0; i < 4; i++) rq[i].push_back(10 * (i + 1));
    plog.delete();
    start_ts();
    run_rsp(25'd99);
    chk("t2_len", plog.size(), 6);
    if (plog.size() == 6) begin
      for (int i = 0; i < 4; i++) chk("t2_order", plog[i], pk(4'd5, 4'd0, 25'(10 * (i + 1))));
      chk("t2_pot", plog[5], pk(4'd5, 4'd2, 25'd7));
    end
    for (int i = 0; i < 4; i++) rq[i].push_back(10 * (i + 1) + 1);
    plog.delete();
    start_ts();
    run_rsp(25'd1);
    chk("t2b_len", plog.size(), 6);
    if (plog.size() == 6) begin
      for (int i = 0; i < 4; i++) chk("t2b_order", plog[i], pk(4'd5, 4'd0, 25'(10 * (i + 1) + 1)));
      chk("t2b_pot", plog[5], pk(4'd5, 4'd2, 25'd99));
    end
    chk("t2_ts_count", ts_count, 2);

    // Test 3: SPE stalls three cycles mid-stream.
    for (int i = 1; i <= 4; i++) rq[1].push_back(i);
    plog.delete();
    start_ts();
    tick(); tick();
    bus.spe_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_stall_ready", bus.req_ready, 0);
      chk("t3_stall_valid", bus.spe_valid, 1);
      chk("t3_stall_packet", bus.spe_packet, pk(4'd5, 4'd0, 25'd2));
    end
    bus.spe_ready = 1;
    run_rsp(25'd2);
    chk("t3_len", plog.size(), 6);
    if (plog.size() == 6)
      for (int i = 0; i < 4; i++) chk("t3_psum", plog[i], pk(4'd5, 4'd0, 25'(i + 1)));
    chk("t3_ts_count", ts_count, 3);

    // Test 5: reset while the potential packet is pending.
    cfg(4'd2, 8'd1, 25'd5);
    rq[3].push_back(8);
    bus.spe_ready = 0;
    plog.delete();
    start_ts();
    tick(); tick();
    bus.spe_ready = 1;
    tick();
    bus.spe_ready = 0;
    tick();
    chk("t5_pre_busy", busy, 1);
    chk("t5_pre_packet", bus.spe_packet, pk(4'd2, 4'd15, 25'd0));
    rst_n = 0;
    #1;
    chk("t5_async_valid", bus.spe_valid, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_ts", ts_count, 0);
    tick();
    rst_n = 1;
    bus.spe_ready = 1;
    tick();
    cfg(4'd2, 8'd1, 25'd5);
    rq[3].push_back(8);
    plog.delete();
    start_ts();
    run_rsp(25'd6);
    chk("t5_len", plog.size(), 3);
    if (plog.size() == 3) begin
      chk("t5_psum", plog[0], pk(4'd2, 4'd0, 25'd8));
      chk("t5_flag", plog[1], pk(4'd2, 4'd15, 25'd0));
      chk("t5_pot", plog[2], pk(4'd2, 4'd2, 25'd5));
    end
    chk("t5_ts_count", ts_count, 1);

    // Test 4: zero psums; a waiting requester must never be granted.
    cfg(4'd9, 8'd0, 25'd33);
    rq[2].push_back(5);
    plog.delete();
    start_ts();
    run_rsp(25'd44);
    chk("t4_len", plog.size(), 2);
    if (plog.size() == 2) begin
      chk("t4_first_flag", plog[0], pk(4'd9, 4'd15, 25'd0));
      chk("t4_pot", plog[1], pk(4'd9, 4'd2, 25'd33));
    end
    chk("t4_ts_count", ts_count, 2);
    rq[2].delete();
    tick(); tick();

    // Test 6: start/config while busy are ignored; ts_count wraps.
    cfg(4'd1, 8'd2, 25'd50);
    plog.delete();
    start_ts();
    cfg_we = 1; cfg_addr = 4'd15; cfg_psum_cnt = 8'd7; cfg_init_pot = 25'd123; start = 1;
    tick();
    cfg_we = 0; start = 0;
    chk("t6_busy", busy, 1);
    rq[0].push_back(1); rq[0].push_back(2);
    run_rsp(25'd3);
    chk("t6_len", plog.size(), 4);
    if (plog.size() == 4) begin
      chk("t6_psum0", plog[0], pk(4'd1, 4'd0, 25'd1));
      chk("t6_psum1", plog[1], pk(4'd1, 4'd0, 25'd2));
      chk("t6_flag", plog[2], pk(4'd1, 4'd15, 25'd0));
      chk("t6_pot", plog[3], pk(4'd1, 4'd2, 25'd50));
    end
    chk("t6_ts_count", ts_count, 3);
    rq[0].push_back(4); rq[0].push_back(5);
    plog.delete();
    start_ts();
    run_rsp(25'd0);
    chk("t6b_len", plog.size(), 4);
    if (plog.size() == 4) chk("t6b_pot_not_cfg", plog[3], pk(4'd1, 4'd2, 25'd3));
    chk("t6_ts_wrap", ts_count, 0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
